// File: rtl/distance_filter.sv
// Moving-average filter for echo distance samples: rejects out-of-range values,
// averages the last 2^WIN_LOG2 accepted samples and drives a hysteretic proximity flag.
module distance_filter #(
   parameter int unsigned DW       = 32,
   parameter int unsigned WIN_LOG2 = 2,
   parameter int unsigned MAX_DIST = 1000000,
   parameter int unsigned NEAR_ON  = 100,
   parameter int unsigned NEAR_OFF = 150
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_distance,
   input  logic          clear,
   output logic          out_valid,
   output logic [DW-1:0] out_distance,
   output logic          near,
   output logic [15:0]   drop_cnt
);

   localparam int WIN = 1 << WIN_LOG2;
   localparam int SW  = int'(DW + WIN_LOG2);

   localparam logic [DW-1:0]       MAX_D   = DW'(MAX_DIST);
   localparam logic [DW-1:0]       ON_THR  = DW'(NEAR_ON);
   localparam logic [DW-1:0]       OFF_THR = DW'(NEAR_OFF);
   localparam logic [WIN_LOG2-1:0] LAST    = WIN_LOG2'(WIN - 1);

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state;
   logic [DW-1:0]       win_buf [WIN];
   logic [WIN_LOG2-1:0] wr_ptr;
   logic [SW-1:0]       sum;
   logic                pend;

   logic                in_range;
   logic                accept;
   logic                reject;
   logic                last_fill;
   logic [DW-1:0]       oldest;
   logic [SW-1:0]       sum_next;
   logic [DW-1:0]       avg;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      in_range  = (in_distance != '0) && (in_distance <= MAX_D);
      accept    = in_valid && !clear && in_range;
      reject    = in_valid && !clear && !in_range;
      // While filling, wr_ptr also counts the accepted samples so far.
      last_fill = (state == FILL) && (wr_ptr == LAST);
      oldest    = '0;
      if (state == RUN) oldest = win_buf[wr_ptr];
      sum_next  = sum + SW'(in_distance) - SW'(oldest);
      avg       = sum[SW-1:WIN_LOG2];
   end

   // Stage 1: window, running sum, pointer, FSM and drop counter.
   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the window is small and must read as empty after reset, so it is
         // reset explicitly rather than left to the FILL-state masking alone.
         for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
         wr_ptr   <= '0;
         sum      <= '0;
         state    <= FILL;
         pend     <= 1'b0;
         drop_cnt <= '0;
      end else if (clear) begin
         for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
         wr_ptr   <= '0;
         sum      <= '0;
         state    <= FILL;
         pend     <= 1'b0;
         drop_cnt <= '0;
      end else begin
         pend <= accept && ((state == RUN) || last_fill);
         if (accept) begin
            win_buf[wr_ptr] <= in_distance;
            wr_ptr          <= wr_ptr + 1'b1;
            sum             <= sum_next;
            if (last_fill) state <= RUN;
         end
         if (reject && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // Stage 2: publish the average and update the hysteretic flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_distance <= '0;
         near         <= 1'b0;
      end else if (clear) begin
         out_valid    <= 1'b0;
         out_distance <= '0;
         near         <= 1'b0;
      end else begin
         out_valid <= pend;
         if (pend) begin
            out_distance <= avg;
            if (avg < ON_THR)       near <= 1'b1;
            else if (avg > OFF_THR) near <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_distance_filter.sv
// Directed bench for distance_filter: hand-computed averages, rejection,
// hysteresis and clear/reset collisions.
module tb_distance_filter;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_distance;
   logic        clear;
   logic        out_valid;
   logic [31:0] out_distance;
   logic        near;
   logic [15:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   distance_filter #(
      .DW(32), .WIN_LOG2(2), .MAX_DIST(1000000), .NEAR_ON(100), .NEAR_OFF(150)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_distance  (in_distance),
      .clear        (clear),
      .out_valid    (out_valid),
      .out_distance (out_distance),
      .near         (near),
      .drop_cnt     (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One-cycle strobe, then look at the outputs two cycles after the strobe cycle.
   task automatic send(input logic [31:0] d, input logic exp_v, input logic [31:0] exp_d,
                       input logic exp_near, input string tag);
      @(negedge clk);
      in_valid    = 1'b1;
      in_distance = d;
      @(negedge clk);
      in_valid    = 1'b0;
      @(negedge clk);
      check({tag, "_valid"}, 32'(out_valid), 32'(exp_v));
      if (exp_v) check({tag, "_dist"}, out_distance, exp_d);
      check({tag, "_near"}, 32'(near), 32'(exp_near));
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_distance = 32'd100;
      clear       = 1'b0;

      // Reset held with in_valid toggling
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
      end
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_dist", out_distance, 32'd0);
      check("rst_near", 32'(near), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Fill: first result after the 4th sample
      send(100, 1'b0, 0, 1'b0, "fill1");
      send(200, 1'b0, 0, 1'b0, "fill2");
      send(300, 1'b0, 0, 1'b0, "fill3");
      send(400, 1'b1, 250, 1'b0, "fill4");
      @(negedge clk);
      check("pulse_width", 32'(out_valid), 32'd0);

      // Back-to-back 500, 600
      @(negedge clk);
      in_valid = 1'b1; in_distance = 500;
      @(negedge clk);
      in_distance = 600;
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_v1", 32'(out_valid), 32'd1);
      check("b2b_d1", out_distance, 32'd350);
      @(negedge clk);
      check("b2b_v2", 32'(out_valid), 32'd1);
      check("b2b_d2", out_distance, 32'd450);

      // Truncation: window ends as 1,2,1,1 (sum 5)
      send(1, 1'b1, 375, 1'b0, "tr1");
      send(1, 1'b1, 275, 1'b0, "tr2");
      send(1, 1'b1, 150, 1'b0, "tr3");
      send(2, 1'b1, 1, 1'b1, "tr4");

      // Rejections leave the window untouched
      send(0, 1'b0, 0, 1'b1, "rej_zero");
      check("rej_drop1", 32'(drop_cnt), 32'd1);
      send(1000001, 1'b0, 0, 1'b1, "rej_big");
      check("rej_drop2", 32'(drop_cnt), 32'd2);
      send(1000000, 1'b1, 250001, 1'b0, "max_ok");
      check("max_drop", 32'(drop_cnt), 32'd2);

      // Hysteresis from a clean window
      pulse_clear();
      check("clr_near", 32'(near), 32'd0);
      check("clr_drop", 32'(drop_cnt), 32'd0);
      check("clr_dist", out_distance, 32'd0);
      send(90, 1'b0, 0, 1'b0, "h90a");
      send(90, 1'b0, 0, 1'b0, "h90b");
      send(90, 1'b0, 0, 1'b0, "h90c");
      send(90, 1'b1, 90, 1'b1, "h90d");
      send(120, 1'b1, 97, 1'b1, "h120a");
      send(120, 1'b1, 105, 1'b1, "h120b");
      send(120, 1'b1, 112, 1'b1, "h120c");
      send(120, 1'b1, 120, 1'b1, "h120d");
      send(160, 1'b1, 130, 1'b1, "h160a");
      send(160, 1'b1, 140, 1'b1, "h160b");
      send(160, 1'b1, 150, 1'b1, "h160c");
      send(160, 1'b1, 160, 1'b0, "h160d");
      send(120, 1'b1, 150, 1'b0, "h120e");
      send(120, 1'b1, 140, 1'b0, "h120f");
      send(120, 1'b1, 130, 1'b0, "h120g");
      send(120, 1'b1, 120, 1'b0, "h120h");

      // clear coincident with the 4th fill sample
      pulse_clear();
      send(0, 1'b0, 0, 1'b0, "cc_rej");
      check("cc_drop_pre", 32'(drop_cnt), 32'd1);
      send(10, 1'b0, 0, 1'b0, "cc1");
      send(20, 1'b0, 0, 1'b0, "cc2");
      send(30, 1'b0, 0, 1'b0, "cc3");
      @(negedge clk);
      in_valid = 1'b1; in_distance = 40; clear = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; clear = 1'b0;
      @(negedge clk);
      check("cc4_valid", 32'(out_valid), 32'd0);
      check("cc4_drop", 32'(drop_cnt), 32'd0);
      send(10, 1'b0, 0, 1'b0, "cf1");
      send(20, 1'b0, 0, 1'b0, "cf2");
      send(30, 1'b0, 0, 1'b0, "cf3");
      send(40, 1'b1, 25, 1'b1, "cf4");

      // clear in the cycle after an accepted RUN sample
      @(negedge clk);
      in_valid = 1'b1; in_distance = 50;
      @(negedge clk);
      in_valid = 1'b0; clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("cs_valid", 32'(out_valid), 32'd0);
      check("cs_dist", out_distance, 32'd0);
      check("cs_near", 32'(near), 32'd0);
      @(negedge clk);
      check("cs_valid2", 32'(out_valid), 32'd0);

      // Async reset while a result is in flight
      send(40, 1'b0, 0, 1'b0, "rs1");
      send(40, 1'b0, 0, 1'b0, "rs2");
      send(40, 1'b0, 0, 1'b0, "rs3");
      send(40, 1'b1, 40, 1'b1, "rs4");
      @(negedge clk);
      in_valid = 1'b1; in_distance = 80;
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      check("rm_valid", 32'(out_valid), 32'd0);
      check("rm_dist", out_distance, 32'd0);
      check("rm_near", 32'(near), 32'd0);
      rst_n = 1'b1;
      send(8, 1'b0, 0, 1'b0, "rm_fill");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
